// File: rtl/sat_rnd.sv
// Two-stage requantiser: round away `lsb` fraction bits, then saturate to `osz` bits.
// Optional saturation statistics (sticky flag, event counter) are built when SAT_RND_STATS_EN is defined.
module sat_rnd #(
    parameter int isz   = 24,
    parameter int osz   = 16,
    parameter int lsb   = 4,
    parameter int cntsz = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [isz-1:0]   in,
    input  logic        [1:0]       rnd_mode,
    output logic                    out_valid,
    output logic signed [osz-1:0]   out,
    output logic                    sat_pos,
    output logic                    sat_neg,
    input  logic                    clr,
    output logic                    sticky,
    output logic        [cntsz-1:0] sat_cnt
);

    // One guard bit above the shifted input so rounding up the largest input cannot wrap.
    localparam int rsz = isz - lsb + 1;

    localparam logic signed [isz:0]     one  = {{isz{1'b0}}, 1'b1};
    localparam logic signed [isz:0]     half = one << (lsb - 1);
    localparam logic signed [rsz-1:0]   maxv = {{(rsz-osz+1){1'b0}}, {(osz-1){1'b1}}};
    localparam logic signed [rsz-1:0]   minv = {{(rsz-osz+1){1'b1}}, {(osz-1){1'b0}}};

    function automatic logic signed [rsz-1:0] round_shift(
        input logic signed [isz-1:0] x,
        input logic        [1:0]     mode
    );
        logic signed [isz:0] ext;
        logic signed [isz:0] rc;
        logic signed [isz:0] sum;
        ext = {x[isz-1], x};
        case (mode)
            2'b01:   rc = half;
            2'b10:   rc = half - one + {{isz{1'b0}}, x[lsb]};
            default: rc = '0;
        endcase
        sum = ext + rc;
        return sum[isz:lsb];
    endfunction

    function automatic logic signed [osz-1:0] saturate(input logic signed [rsz-1:0] v);
        if (v > maxv)
            return maxv[osz-1:0];
        else if (v < minv)
            return minv[osz-1:0];
        else
            return v[osz-1:0];
    endfunction

    logic signed [rsz-1:0] val_p1;
    logic                  vld_p1;
    logic                  vld_p2;

    // Stage 1: rounding and shift
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            val_p1 <= '0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid)
                val_p1 <= round_shift(in, rnd_mode);
        end
    end

    // Stage 2: saturation; flags only pulse alongside a valid output
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2  <= 1'b0;
            out     <= '0;
            sat_pos <= 1'b0;
            sat_neg <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                out     <= saturate(val_p1);
                sat_pos <= (val_p1 > maxv);
                sat_neg <= (val_p1 < minv);
            end else begin
                sat_pos <= 1'b0;
                sat_neg <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p2;

`ifdef SAT_RND_STATS_EN
    logic sat_evt;
    assign sat_evt = vld_p2 & (sat_pos | sat_neg);

    // A saturation event takes priority over a coincident clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky  <= 1'b0;
            sat_cnt <= '0;
        end else if (sat_evt) begin
            sticky <= 1'b1;
            if (clr)
                sat_cnt <= cntsz'(1);
            else if (sat_cnt != {cntsz{1'b1}})
                sat_cnt <= sat_cnt + cntsz'(1);
        end else if (clr) begin
            sticky  <= 1'b0;
            sat_cnt <= '0;
        end
    end
`else
    logic unused_clr;
    assign unused_clr = clr;
    assign sticky     = 1'b0;
    assign sat_cnt    = '0;
`endif

endmodule
